// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and key classification helper
// for the keypad password checker.
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Debounces the scanner key code and emits a one-cycle event when a new,
// stable value differs from the last accepted one.
module key_event_detect
  import keypad_pkg::*;
#(
  parameter int STABLE_TICKS = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(STABLE_TICKS + 2);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);

  logic [3:0]    cur_p0;
  logic [CW-1:0] cnt_p0;
  logic [CW-1:0] hold;
  logic          stable;
  logic [3:0]    base;
  logic          base_vld;

  // hold tops out at STABLE_C+1 so a long-held key fires exactly once
  function automatic logic [CW-1:0] sat_hold(input logic [CW-1:0] h);
    return (h > STABLE_C) ? STABLE_C : h;
  endfunction

  always_comb begin
    hold   = (key == cur_p0) ? cnt_p0 + CW'(1) : CW'(1);
    stable = (hold == STABLE_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_p0    <= 4'h0;
      cnt_p0    <= '0;
      base      <= 4'h0;
      base_vld  <= 1'b0;
      key_event <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      cur_p0    <= key;
      cnt_p0    <= sat_hold(hold);
      key_event <= 1'b0;
      if (stable) begin
        // First stable value only seeds the baseline
        if (!base_vld) begin
          base_vld <= 1'b1;
          base     <= key;
        end else if (key != base) begin
          base      <= key;
          key_event <= 1'b1;
          key_code  <= key;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_password_check.sv
// Keypad password checker: buffers digits, compares on enter, unlocks on a
// match and locks out for a fixed time after repeated failures.
module keypad_password_check
  import keypad_pkg::*;
#(
  parameter int          STABLE_TICKS = 1000000,
  parameter int          PW_LEN       = 4,
  parameter logic [31:0] PASSWORD     = 32'h0000_1357,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCK_TICKS   = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       key_event,
  output logic [3:0] digit_count,
  output logic       unlock,
  output logic       fail,
  output logic       locked
);

  localparam int BW = 4 * PW_LEN;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  localparam logic [BW-1:0] PW_C      = PASSWORD[BW-1:0];
  localparam logic [3:0]    PW_LEN_C  = 4'(PW_LEN);
  localparam logic [FW-1:0] MAX_C     = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TICKS - 1);

  logic [3:0]    key_code;
  state_t        state, state_nx;
  logic [BW-1:0] digits, digits_nx;
  logic [3:0]    count, count_nx;
  logic [FW-1:0] fails, fails_nx;
  logic [LW-1:0] timer, timer_nx;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v >= MAX_C) ? MAX_C : v + FW'(1);
  endfunction

  key_event_detect #(
    .STABLE_TICKS(STABLE_TICKS)
  ) u_detect (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .key_event(key_event),
    .key_code (key_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_ENTRY;
      digits <= '0;
      count  <= 4'd0;
      fails  <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nx;
      digits <= digits_nx;
      count  <= count_nx;
      fails  <= fails_nx;
      timer  <= timer_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    digits_nx = digits;
    count_nx  = count;
    fails_nx  = fails;
    timer_nx  = timer;
    fail      = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (key_event) begin
          if (is_digit(key_code)) begin
            if (count < PW_LEN_C) begin
              digits_nx = BW'({digits, key_code});
              count_nx  = count + 4'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            digits_nx = '0;
            count_nx  = 4'd0;
          end else if (key_code == KEY_ENTER) begin
            state_nx = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // The buffer is consumed by every attempt, good or bad
        digits_nx = '0;
        count_nx  = 4'd0;
        if ((count == PW_LEN_C) && (digits == PW_C)) begin
          state_nx = ST_UNLOCKED;
          fails_nx = '0;
        end else begin
          fail     = 1'b1;
          fails_nx = sat_inc(fails);
          timer_nx = '0;
          state_nx = (sat_inc(fails) == MAX_C) ? ST_LOCKED : ST_ENTRY;
        end
      end
      ST_UNLOCKED: begin
        if (key_event && (key_code == KEY_CLEAR)) begin
          state_nx = ST_ENTRY;
        end
      end
      ST_LOCKED: begin
        if (timer == LOCK_LAST) begin
          state_nx = ST_ENTRY;
          timer_nx = '0;
          fails_nx = '0;
        end else begin
          timer_nx = timer + LW'(1);
        end
      end
      default: state_nx = ST_ENTRY;
    endcase
  end

  always_comb begin
    digit_count = count;
    unlock      = (state == ST_UNLOCKED);
    locked      = (state == ST_LOCKED);
  end

endmodule

// File: tb/tb_keypad_password_check.sv
// Directed bench for keypad_password_check with short debounce and lockout.
module tb_keypad_password_check;

  localparam logic [3:0] KE = 4'hE;
  localparam logic [3:0] KF = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       key_event;
  logic [3:0] digit_count;
  logic       unlock;
  logic       fail;
  logic       locked;

  int n_vec = 0;
  int n_bad = 0;
  int ev_cnt = 0;
  int fail_cnt = 0;
  int e0, f0;

  keypad_password_check #(
    .STABLE_TICKS(4),
    .PW_LEN      (4),
    .PASSWORD    (32'h0000_1357),
    .MAX_FAIL    (3),
    .LOCK_TICKS  (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_event  (key_event),
    .digit_count(digit_count),
    .unlock     (unlock),
    .fail       (fail),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_event) ev_cnt++;
    if (fail) fail_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Key set just after an edge is accepted on the 4th edge; event visible after it
  task automatic press(input logic [3:0] k, input logic exp_ev);
    key = k;
    tick(4);
    check("key_event", 32'(key_event), 32'(exp_ev));
    tick(2);
  endtask

  task automatic enter(input logic exp_fail, input logic exp_locked, input logic exp_unlock);
    key = KE;
    tick(4);
    check("enter_event", 32'(key_event), 32'd1);
    check("fail_before_check", 32'(fail), 32'd0);
    tick(1);
    check("fail_in_check", 32'(fail), 32'(exp_fail));
    check("unlock_in_check", 32'(unlock), 32'd0);
    tick(1);
    check("fail_after_check", 32'(fail), 32'd0);
    check("locked_after_check", 32'(locked), 32'(exp_locked));
    check("unlock_after_check", 32'(unlock), 32'(exp_unlock));
    if (exp_fail) check("count_after_fail", 32'(digit_count), 32'd0);
  endtask

  task automatic wrong_attempt(input logic exp_locked);
    press(4'h1, 1'b1);
    press(4'h3, 1'b1);
    press(4'h5, 1'b1);
    press(4'h6, 1'b1);
    check("count_wrong_full", 32'(digit_count), 32'd4);
    enter(1'b1, exp_locked, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    key = 4'h0;
    tick(3);
    check("rst_key_event", 32'(key_event), 32'd0);
    check("rst_digit_count", 32'(digit_count), 32'd0);
    check("rst_unlock", 32'(unlock), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    // Baseline 0 then the correct password
    e0 = ev_cnt;
    f0 = fail_cnt;
    tick(8);
    check("baseline_no_event", 32'(ev_cnt - e0), 32'd0);
    press(4'h1, 1'b1); check("count1", 32'(digit_count), 32'd1);
    press(4'h3, 1'b1); check("count2", 32'(digit_count), 32'd2);
    press(4'h5, 1'b1); check("count3", 32'(digit_count), 32'd3);
    press(4'h7, 1'b1); check("count4", 32'(digit_count), 32'd4);
    enter(1'b0, 1'b0, 1'b1);
    check("good_events", 32'(ev_cnt - e0), 32'd5);
    check("good_no_fail", 32'(fail_cnt - f0), 32'd0);

    // Clear while unlocked relocks on the next cycle
    key = KF;
    tick(4);
    check("clr_event", 32'(key_event), 32'd1);
    check("clr_unlock_still", 32'(unlock), 32'd1);
    tick(1);
    check("clr_unlock_off", 32'(unlock), 32'd0);
    tick(1);

    // Glitch to 2 restarts the stability count for 3
    e0 = ev_cnt;
    key = 4'h3; tick(2);
    key = 4'h2; tick(2);
    key = 4'h3; tick(3);
    check("glitch_no_event_yet", 32'(key_event), 32'd0);
    check("glitch_count0", 32'(digit_count), 32'd0);
    tick(1);
    check("glitch_event", 32'(key_event), 32'd1);
    tick(1);
    check("glitch_count1", 32'(digit_count), 32'd1);
    check("glitch_one_event", 32'(ev_cnt - e0), 32'd1);
    tick(1);
    press(KF, 1'b1);
    check("clear_count", 32'(digit_count), 32'd0);

    // Three wrong attempts lock out for 50 cycles
    f0 = fail_cnt;
    wrong_attempt(1'b0);
    wrong_attempt(1'b0);
    wrong_attempt(1'b1);
    check("three_fails", 32'(fail_cnt - f0), 32'd3);
    press(4'h9, 1'b1);
    check("locked_key_ignored", 32'(digit_count), 32'd0);
    check("locked_mid", 32'(locked), 32'd1);
    tick(43);
    check("locked_last_cycle", 32'(locked), 32'd1);
    tick(1);
    check("lock_expired", 32'(locked), 32'd0);

    // Short entry fails; extra digit beyond PW_LEN is ignored
    press(4'h1, 1'b1);
    press(4'h3, 1'b1);
    enter(1'b1, 1'b0, 1'b0);
    press(4'h1, 1'b1);
    press(4'h3, 1'b1);
    press(4'h5, 1'b1);
    press(4'h7, 1'b1);
    press(4'h9, 1'b1);
    check("ninth_ignored", 32'(digit_count), 32'd4);
    enter(1'b0, 1'b0, 1'b1);

    // Reset during a second lockout
    press(KF, 1'b1);
    check("relock_unlock_off", 32'(unlock), 32'd0);
    wrong_attempt(1'b0);
    wrong_attempt(1'b0);
    wrong_attempt(1'b1);
    tick(10);
    check("lock2_active", 32'(locked), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rst_lock_locked", 32'(locked), 32'd0);
    check("rst_lock_count", 32'(digit_count), 32'd0);
    check("rst_lock_unlock", 32'(unlock), 32'd0);
    check("rst_lock_event", 32'(key_event), 32'd0);
    rst = 1'b0;
    tick(2);
    check("post_rst_locked", 32'(locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
